// File: rtl/bch_short_pkg.sv
// bch_short_pkg: DVB-S2 short-frame t=12 BCH generator polynomial, parity width and checker FSM states.
package bch_short_pkg;
  localparam int PAR_W = 168;
  localparam logic [12*15-1:0] G_FACTORS = {
    15'h65EF, 15'h5811, 15'h5A49, 15'h460F, 15'h4F21, 15'h6CE5,
    15'h6389, 15'h6B55, 15'h5591, 15'h4647, 15'h4941, 15'h402B};
  // g(x) is the product of the twelve degree-14 minimal polynomials g1..g12
  function automatic logic [PAR_W:0] poly_product();
    logic [PAR_W:0] p;
    logic [PAR_W:0] q;
    p = '0;
    p[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      q = '0;
      for (int j = 0; j < 15; j++)
        if (G_FACTORS[k*15+j]) q = q ^ (p << j);
      p = q;
    end
    return p;
  endfunction
  localparam logic [PAR_W:0] G_POLY_SHORT_T12 = poly_product();
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bch_short_div_step.sv
// bch_short_div_step: combinational DW-bit remainder update r' = (r * x^DW + data) mod g(x), MSB first.
module bch_short_div_step
  import bch_short_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [PAR_W-1:0] rem_in,
  input  logic [DW-1:0]    data,
  output logic [PAR_W-1:0] rem_out
);
  localparam logic [PAR_W-1:0] G_LOW = G_POLY_SHORT_T12[PAR_W-1:0];
  always_comb begin
    rem_out = rem_in;
    for (int i = DW - 1; i >= 0; i--)
      rem_out = {rem_out[PAR_W-2:0], data[i]} ^ (rem_out[PAR_W-1] ? G_LOW : '0);
  end
endmodule

// File: rtl/bch_short_t12_checker.sv
// bch_short_t12_checker: framed BCH syndrome checker for DVB-S2 short t=12 codewords.
// Defining BCH_CHK_ERR_CNT_EN adds a saturating err_cnt output.
module bch_short_t12_checker
  import bch_short_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk_1x,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             chk_valid,
  output logic             chk_err,
  output logic [PAR_W-1:0] rem_q,
  output logic [13:0]      frm_bits
`ifdef BCH_CHK_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);
  state_t           state;
  logic [PAR_W-1:0] lfsr;
  logic [PAR_W-1:0] seed;
  logic [PAR_W-1:0] rem_nxt;
  logic [13:0]      cnt;
  logic [13:0]      cnt_nxt;
  logic [14:0]      cnt_sum;
  logic             take;
  assign in_ready = rst_n && state != DONE;
  // in IDLE only a sof beat opens a frame; in RUN every accepted beat counts
  assign take    = in_valid && in_ready && (in_sof || state == RUN);
  assign seed    = in_sof ? '0 : lfsr;
  assign cnt_sum = (in_sof ? 15'd0 : {1'b0, cnt}) + 15'(DW);
  assign cnt_nxt = cnt_sum > 15'd16383 ? 14'h3FFF : cnt_sum[13:0];
  bch_short_div_step #(.DW(DW)) u_step (
    .rem_in (seed),
    .data   (in_data),
    .rem_out(rem_nxt)
  );
  always_ff @(posedge clk_1x) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= '0;
      cnt       <= '0;
      chk_valid <= 1'b0;
      chk_err   <= 1'b0;
      rem_q     <= '0;
      frm_bits  <= '0;
`ifdef BCH_CHK_ERR_CNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      chk_valid <= 1'b0;
      if (state == DONE) begin
        state <= IDLE;
      end else if (take) begin
        lfsr  <= rem_nxt;
        cnt   <= cnt_nxt;
        state <= in_eof ? DONE : RUN;
        if (in_eof) begin
          chk_valid <= 1'b1;
          chk_err   <= |rem_nxt;
          rem_q     <= rem_nxt;
          frm_bits  <= cnt_nxt;
`ifdef BCH_CHK_ERR_CNT_EN
          err_cnt   <= (|rem_nxt && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
`endif
        end
      end
    end
  end
endmodule
